// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 scan-code set 2 decoder: special byte
// values, decode FSM state encoding and the 10-bit key event layout.
package ps2_key_decoder_pkg;

   // Prefix bytes
   localparam logic [7:0] SC_E0 = 8'hE0;
   localparam logic [7:0] SC_E1 = 8'hE1;
   localparam logic [7:0] SC_F0 = 8'hF0;

   // Keyboard status / response bytes
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_ERR_00 = 8'h00;
   localparam logic [7:0] SC_ERR_FC = 8'hFC;
   localparam logic [7:0] SC_ERR_FF = 8'hFF;

   // Extended shift codes the keyboard inserts around some E0 keys
   localparam logic [7:0] SC_FAKE_LSHIFT = 8'h12;
   localparam logic [7:0] SC_FAKE_RSHIFT = 8'h59;

   // Bytes that follow E1 in the Pause make sequence before it is complete
   localparam logic [2:0] E1_SKIP_LEN = 3'd7;

   // Event layout: {ext, brk, code[7:0]}
   localparam int EV_WIDTH   = 10;
   localparam int EV_EXT_BIT = 9;
   localparam int EV_BRK_BIT = 8;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_event_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GOT_E0   = 3'd1,
      GOT_F0   = 3'd2,
      GOT_E0F0 = 3'd3,
      E1_SKIP  = 3'd4
   } decode_state_t;

   function automatic key_event_t make_event(input logic ext, input logic brk,
                                             input logic [7:0] code);
      key_event_t ev;
      ev.ext  = ext;
      ev.brk  = brk;
      ev.code = code;
      return ev;
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead FIFO for decoded key events. The head entry is presented
// combinationally; a push into a full FIFO is only accepted when a pop
// frees a slot in the same cycle, otherwise it is dropped and recorded
// in the sticky overflow flag.
module ps2_event_fifo
   import ps2_key_decoder_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [EV_WIDTH-1:0]      wr_data,
   input  logic                     rd_en,
   output logic [EV_WIDTH-1:0]      rd_data,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [EV_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic                empty;
   logic                full;
   logic                do_pop;
   logic                do_push;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign do_pop  = rd_en && !empty;
   assign do_push = wr_en && (!full || do_pop);

   assign valid   = !empty;
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Storage array; contents need no reset because empty masks the head
   always_ff @(posedge CLOCK_50) begin
      if (!reset && do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and the sticky overflow flag
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_en && full && !do_pop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder. Folds E0/F0/E1 prefixes into 10-bit key
// events {ext, brk, code}, drops the fake shift codes, pulses status
// outputs for keyboard responses and queues events in ps2_event_fifo.
// Events are pushed in the same cycle the completing byte arrives so they
// become visible on the following cycle.
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int PREFIX_TIMEOUT = 1048576
) (
   input  logic                          CLOCK_50,
   input  logic                          reset,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   input  logic                          rd_en,
   output logic                          ev_valid,
   output logic [EV_WIDTH-1:0]           ev_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          ack_seen,
   output logic                          bat_ok,
   output logic                          kbd_error
);

   localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(PREFIX_TIMEOUT - 1);

   decode_state_t state;
   decode_state_t state_next;
   logic [2:0]    skip_cnt;
   logic [2:0]    skip_next;
   logic [TW-1:0] timer;
   logic          timed_out;
   logic          push_en;
   key_event_t    push_event;
   logic          ack_next;
   logic          bat_next;
   logic          err_next;

   assign timed_out = (state != IDLE) && !rx_valid && (timer == TIMEOUT_LAST);

   // Decode the incoming byte against the current prefix state
   always_comb begin
      state_next = state;
      skip_next  = skip_cnt;
      push_en    = 1'b0;
      push_event = '0;
      ack_next   = 1'b0;
      bat_next   = 1'b0;
      err_next   = 1'b0;
      if (rx_valid) begin
         case (state)
            IDLE: begin
               case (rx_data)
                  SC_E0: state_next = GOT_E0;
                  SC_F0: state_next = GOT_F0;
                  SC_E1: begin
                     state_next = E1_SKIP;
                     skip_next  = E1_SKIP_LEN;
                  end
                  SC_ACK:                        ack_next = 1'b1;
                  SC_BAT:                        bat_next = 1'b1;
                  SC_ERR_00, SC_ERR_FC, SC_ERR_FF: err_next = 1'b1;
                  default: begin
                     push_en    = 1'b1;
                     push_event = make_event(1'b0, 1'b0, rx_data);
                  end
               endcase
            end
            GOT_E0: begin
               if (rx_data == SC_F0) begin
                  state_next = GOT_E0F0;
               end else begin
                  state_next = IDLE;
                  if (rx_data != SC_FAKE_LSHIFT && rx_data != SC_FAKE_RSHIFT) begin
                     push_en    = 1'b1;
                     push_event = make_event(1'b1, 1'b0, rx_data);
                  end
               end
            end
            GOT_F0: begin
               state_next = IDLE;
               push_en    = 1'b1;
               push_event = make_event(1'b0, 1'b1, rx_data);
            end
            GOT_E0F0: begin
               state_next = IDLE;
               if (rx_data != SC_FAKE_LSHIFT && rx_data != SC_FAKE_RSHIFT) begin
                  push_en    = 1'b1;
                  push_event = make_event(1'b1, 1'b1, rx_data);
               end
            end
            E1_SKIP: begin
               skip_next = skip_cnt - 1'b1;
               if (skip_cnt == 3'd1) begin
                  state_next = IDLE;
                  push_en    = 1'b1;
                  push_event = make_event(1'b1, 1'b0, SC_E1);
               end
            end
            default: state_next = IDLE;
         endcase
      end else if (timed_out) begin
         state_next = IDLE;
         skip_next  = '0;
      end
   end

   // Register FSM state, counters and the one-cycle status pulses
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state     <= IDLE;
         skip_cnt  <= '0;
         timer     <= '0;
         ack_seen  <= 1'b0;
         bat_ok    <= 1'b0;
         kbd_error <= 1'b0;
      end else begin
         state     <= state_next;
         skip_cnt  <= skip_next;
         ack_seen  <= ack_next;
         bat_ok    <= bat_next;
         kbd_error <= err_next;
         if (rx_valid || state == IDLE || timed_out) begin
            timer <= '0;
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .wr_en    (push_en && !reset),
      .wr_data  (push_event),
      .rd_en    (rd_en),
      .rd_data  (ev_data),
      .valid    (ev_valid),
      .count    (fifo_count),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: a table of single-byte vectors with
// hand-computed events and status pulses, followed by hand-written
// sequences for FIFO full/overflow, prefix timeout and reset behaviour.
module tb_ps2_key_decoder;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 16;

   logic                     CLOCK_50 = 1'b0;
   logic                     reset    = 1'b1;
   logic [7:0]               rx_data  = 8'h00;
   logic                     rx_valid = 1'b0;
   logic                     rd_en    = 1'b0;
   logic                     ev_valid;
   logic [9:0]               ev_data;
   logic [$clog2(DEPTH):0]   fifo_count;
   logic                     overflow;
   logic                     ack_seen;
   logic                     bat_ok;
   logic                     kbd_error;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic [7:0] b;
      logic       exp_push;
      logic [9:0] exp_ev;
      logic [2:0] exp_status;
   } vec_t;

   vec_t vecs[$];

   ps2_key_decoder #(
      .FIFO_DEPTH     (DEPTH),
      .PREFIX_TIMEOUT (TIMEOUT)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rd_en      (rd_en),
      .ev_valid   (ev_valid),
      .ev_data    (ev_data),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .ack_seen   (ack_seen),
      .bat_ok     (bat_ok),
      .kbd_error  (kbd_error)
   );

   // Free-running 100 MHz-style clock
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic void add_vec(input logic [7:0] b, input logic p,
                                   input logic [9:0] e, input logic [2:0] s);
      vecs.push_back('{b, p, e, s});
   endfunction

   // Called at a negedge; presents one byte for exactly one rising edge
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge CLOCK_50);
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      reset    = 1'b0;
      rx_valid = 1'b0;
   endtask

   // Sends one byte, checks the cycle-after result, pops any event and
   // checks that status pulses lasted a single cycle
   task automatic apply_stimulus(input vec_t v, input string tag);
      send_byte(v.b);
      check_output({tag, "_valid"}, 32'(ev_valid), 32'(v.exp_push));
      if (v.exp_push) begin
         check_output({tag, "_data"}, 32'(ev_data), 32'(v.exp_ev));
      end
      check_output({tag, "_status"}, 32'({ack_seen, bat_ok, kbd_error}),
                   32'(v.exp_status));
      rd_en = v.exp_push;
      @(negedge CLOCK_50);
      rd_en = 1'b0;
      check_output({tag, "_after"}, 32'({ev_valid, ack_seen, bat_ok, kbd_error}), 32'(0));
   endtask

   initial begin
      logic [7:0] exp_code;

      // Make/break, E0 with fake shifts, Pause, status bytes
      add_vec(8'h1C, 1'b1, 10'h01C, 3'b000);
      add_vec(8'hF0, 1'b0, 10'h000, 3'b000);
      add_vec(8'h1C, 1'b1, 10'h11C, 3'b000);
      add_vec(8'hE0, 1'b0, 10'h000, 3'b000);
      add_vec(8'h12, 1'b0, 10'h000, 3'b000);
      add_vec(8'hE0, 1'b0, 10'h000, 3'b000);
      add_vec(8'h75, 1'b1, 10'h275, 3'b000);
      add_vec(8'hE0, 1'b0, 10'h000, 3'b000);
      add_vec(8'hF0, 1'b0, 10'h000, 3'b000);
      add_vec(8'h75, 1'b1, 10'h375, 3'b000);
      add_vec(8'hE0, 1'b0, 10'h000, 3'b000);
      add_vec(8'hF0, 1'b0, 10'h000, 3'b000);
      add_vec(8'h12, 1'b0, 10'h000, 3'b000);
      add_vec(8'hE0, 1'b0, 10'h000, 3'b000);
      add_vec(8'h59, 1'b0, 10'h000, 3'b000);
      add_vec(8'hE1, 1'b0, 10'h000, 3'b000);
      add_vec(8'h14, 1'b0, 10'h000, 3'b000);
      add_vec(8'h77, 1'b0, 10'h000, 3'b000);
      add_vec(8'hE1, 1'b0, 10'h000, 3'b000);
      add_vec(8'hF0, 1'b0, 10'h000, 3'b000);
      add_vec(8'h14, 1'b0, 10'h000, 3'b000);
      add_vec(8'hF0, 1'b0, 10'h000, 3'b000);
      add_vec(8'h77, 1'b1, 10'h2E1, 3'b000);
      add_vec(8'hFA, 1'b0, 10'h000, 3'b100);
      add_vec(8'hAA, 1'b0, 10'h000, 3'b010);
      add_vec(8'hFC, 1'b0, 10'h000, 3'b001);
      add_vec(8'h00, 1'b0, 10'h000, 3'b001);
      add_vec(8'hFF, 1'b0, 10'h000, 3'b001);
      add_vec(8'h2A, 1'b1, 10'h02A, 3'b000);

      do_reset();
      check_output("reset_outputs",
                   32'({ev_valid, ev_data, overflow, ack_seen, bat_ok, kbd_error}), 32'(0));
      check_output("reset_count", 32'(fifo_count), 32'(0));

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i], $sformatf("vec%0d", i));
      end

      // Fill past capacity with no reads: 0x15..0x1C stored, 0x1D dropped
      for (int i = 0; i < 9; i++) begin
         send_byte(8'(8'h15 + i));
      end
      check_output("full_count", 32'(fifo_count), 32'(8));
      check_output("full_overflow", 32'(overflow), 32'(1));
      check_output("full_head", 32'(ev_data), 32'(10'h015));

      // Push and pop together while full
      rx_data  = 8'h2B;
      rx_valid = 1'b1;
      rd_en    = 1'b1;
      @(negedge CLOCK_50);
      rx_valid = 1'b0;
      rd_en    = 1'b0;
      check_output("pushpop_full_count", 32'(fifo_count), 32'(8));
      check_output("pushpop_full_head", 32'(ev_data), 32'(10'h016));

      // Drain and confirm order across the pointer wrap
      for (int i = 0; i < 8; i++) begin
         exp_code = (i < 7) ? 8'(8'h16 + i) : 8'h2B;
         check_output($sformatf("drain%0d_data", i), 32'(ev_data), 32'({2'b00, exp_code}));
         check_output($sformatf("drain%0d_count", i), 32'(fifo_count), 32'(8 - i));
         rd_en = 1'b1;
         @(negedge CLOCK_50);
         rd_en = 1'b0;
      end
      check_output("drained_empty", 32'({ev_valid, ev_data}), 32'(0));
      check_output("overflow_sticky", 32'(overflow), 32'(1));

      // Pop while empty is ignored
      rd_en = 1'b1;
      @(negedge CLOCK_50);
      rd_en = 1'b0;
      check_output("pop_empty_count", 32'(fifo_count), 32'(0));

      // Push and pop together while empty pushes only
      rx_data  = 8'h1C;
      rx_valid = 1'b1;
      rd_en    = 1'b1;
      @(negedge CLOCK_50);
      rx_valid = 1'b0;
      rd_en    = 1'b0;
      check_output("pushpop_empty_count", 32'(fifo_count), 32'(1));
      check_output("pushpop_empty_data", 32'(ev_data), 32'(10'h01C));
      rd_en = 1'b1;
      @(negedge CLOCK_50);
      rd_en = 1'b0;

      do_reset();
      check_output("overflow_cleared", 32'(overflow), 32'(0));

      // One cycle short of the timeout: prefix still applies
      send_byte(8'hE0);
      repeat (TIMEOUT - 1) @(negedge CLOCK_50);
      apply_stimulus('{8'h1C, 1'b1, 10'h21C, 3'b000}, "timeout_minus1");

      // Full timeout: prefix abandoned, byte decoded from IDLE
      send_byte(8'hE0);
      repeat (TIMEOUT) @(negedge CLOCK_50);
      apply_stimulus('{8'h1C, 1'b1, 10'h01C, 3'b000}, "timeout_exact");

      // Timeout also abandons a partial Pause sequence
      send_byte(8'hE1);
      send_byte(8'h14);
      repeat (TIMEOUT) @(negedge CLOCK_50);
      apply_stimulus('{8'h77, 1'b1, 10'h077, 3'b000}, "timeout_e1");

      // Reset mid-sequence discards F0; bytes during reset are ignored
      send_byte(8'hF0);
      rx_data  = 8'h1C;
      rx_valid = 1'b1;
      do_reset();
      check_output("reset_rx_ignored", 32'({ev_valid, fifo_count}), 32'(0));
      @(negedge CLOCK_50);
      check_output("reset_rx_ignored2", 32'({ev_valid, fifo_count}), 32'(0));
      apply_stimulus('{8'h1C, 1'b1, 10'h01C, 3'b000}, "after_reset");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth; power of 2, 2..64.
REQ-002 SHALL have parameter PREFIX_TIMEOUT, default 1048576, CLOCK_50 cycles allowed between bytes of one multi-byte sequence.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  scan-code byte from the PS/2 receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data valid.
REQ-007 SHALL have port rd_en  input  1  consumer pops the head event.
REQ-008 SHALL have port ev_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port ev_data  output  10  head event {ext, brk, code[7:0]}.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy.
REQ-011 SHALL have port overflow  output  1  sticky; an event was dropped.
REQ-012 SHALL have port ack_seen  output  1  one-cycle pulse on received 0xFA.
REQ-013 SHALL have port bat_ok  output  1  one-cycle pulse on received 0xAA.
REQ-014 SHALL have port kbd_error  output  1  one-cycle pulse on received 0x00, 0xFC or 0xFF.

Function
REQ-015 SHALL decode scan-code set 2 with FSM states IDLE, GOT_E0, GOT_F0, GOT_E0F0, E1_SKIP; bytes are processed only in cycles with rx_valid=1.
REQ-016 IDLE transitions: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; 0xE1 -> E1_SKIP with skip counter 7; 0xFA/0xAA/0x00/0xFC/0xFF -> pulse the matching status output, no push, stay IDLE; any other byte -> push {0,0,b}.
REQ-017 GOT_E0 transitions: 0xF0 -> GOT_E0F0; 0x12 or 0x59 (fake shift) -> drop, IDLE; other -> push {1,0,b}, IDLE.
REQ-018 GOT_F0 transitions: any byte -> push {0,1,b}, IDLE.
REQ-019 GOT_E0F0 transitions: 0x12 or 0x59 -> drop, IDLE; other -> push {1,1,b}, IDLE.
REQ-020 E1_SKIP: each byte decrements the skip counter; the byte that brings it to 0 pushes {1,0,0xE1} (Pause) and returns to IDLE.
REQ-021 In any state other than IDLE, PREFIX_TIMEOUT cycles without rx_valid SHALL return the FSM to IDLE with no push; the timeout counter clears on every rx_valid.
REQ-022 Latency: a pushing byte at cycle n into an empty FIFO SHALL give ev_valid=1 with that event on ev_data at cycle n+1.
REQ-023 Status pulses SHALL assert in cycle n+1 for a byte accepted at cycle n.
REQ-024 FIFO SHALL be show-ahead: ev_data always reflects the head entry while ev_valid=1.
REQ-025 rd_en while empty SHALL be ignored.
REQ-026 A push while full and without a pop SHALL drop the new event and set overflow, which holds until reset.
REQ-027 A simultaneous push and pop while full SHALL both take effect, with no overflow.
REQ-028 A simultaneous push and pop while empty SHALL push only.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 fifo_count SHALL update in the cycle after each push or pop and range 0..FIFO_DEPTH.

Reset
REQ-031 Reset SHALL force: FSM to IDLE; skip and timeout counters to 0; FIFO empty; ev_valid=0, ev_data=0, fifo_count=0, overflow=0, ack_seen=0, bat_ok=0, kbd_error=0.
REQ-032 Reset asserted mid-sequence SHALL discard the pending prefix; the byte following reset release is decoded from IDLE.
REQ-033 rx_valid during reset SHALL be ignored.

Structure
REQ-034 A shared package SHALL hold the prefix and status byte constants (0xE0, 0xE1, 0xF0, 0xFA, 0xAA, 0xFC), the FSM state encoding and the 10-bit event field layout.
REQ-035 The FIFO SHALL be a separate sub-module named ps2_event_fifo (parameter DEPTH, width 10); the decode FSM stays in ps2_key_decoder.

Verification
REQ-036 Bytes 0x1C, then 0xF0 0x1C -> events {0,0,0x1C} then {0,1,0x1C}; ev_valid 1 cycle after the first byte.
REQ-037 Bytes E0 12 E0 75, then E0 F0 75 E0 F0 12 -> only events {1,0,0x75} and {1,1,0x75} are pushed; fake shifts are dropped.
REQ-038 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {1,0,0xE1}, FSM back in IDLE.
REQ-039 With no reads, push 9 make codes into the depth-8 FIFO -> fifo_count=8, overflow=1, head still the first code; then push while rd_en=1 -> count stays 8, codes preserved in order.
REQ-040 Bytes 0xFA, 0xAA, 0xFC -> ack_seen, bat_ok and kbd_error each pulse for one cycle, no events pushed.
REQ-041 Byte 0xE0, then PREFIX_TIMEOUT idle cycles, then 0x1C -> event {0,0,0x1C}; a separate run with 0xF0 followed by reset, then 0x1C -> event {0,0,0x1C}.
